// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared op/state encodings and parameter checks for the
//             digit-serial LUT multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic bit digit_legal(input int digit);
    return (digit == 1) || (digit == 2) || (digit == 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_digit_mult.sv
`default_nettype none
// ============================================================================
//  Module   : lut_digit_mult
//  Brief    : Combinational table of k*mcand (k = 0..2^DIGIT-1) and digit select.
//  Revision : 1.0 - initial release
// ============================================================================
module lut_digit_mult
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       i_mcand,
  input  logic [DIGIT-1:0]       i_digit,
  output logic [WIDTH+DIGIT-1:0] o_multiple
);

  localparam int LW      = WIDTH + DIGIT;
  localparam int ENTRIES = 1 << DIGIT;

  logic [LW-1:0] w_tab [ENTRIES];

  generate
    if (!digit_legal(DIGIT)) begin : g_bad_digit
      $error("lut_digit_mult: DIGIT must be 1, 2 or 4");
    end

    for (genvar k = 0; k < ENTRIES; k++) begin : g_entry
      assign w_tab[k] = LW'(k) * {{DIGIT{1'b0}}, i_mcand};
    end
  endgenerate

  assign o_multiple = w_tab[i_digit];

endmodule
`default_nettype wire

// File: rtl/lut_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lut_multiplier_seq
//  Brief    : Digit-serial RV32M multiplier (MUL/MULH/MULHSU/MULHU), DIGIT
//             multiplier bits per cycle, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module lut_multiplier_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     num0,
  input  logic [WIDTH-1:0]     num1,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = WIDTH + DIGIT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("lut_multiplier_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_result;

  logic                 w_in_ready, w_out_valid, w_accept;
  logic                 w_s0, w_s1;
  logic [WIDTH-1:0]     w_abs0, w_abs1;
  logic [LW-1:0]        w_lut;
  logic [2*WIDTH-1:0]   w_term, w_acc_nxt, w_prod_fix;

  // MUL low half is sign-independent, so only the high-half ops honour signs.
  assign w_s0   = ((op == OP_MULH) || (op == OP_MULHSU)) && num0[WIDTH-1];
  assign w_s1   = (op == OP_MULH) && num1[WIDTH-1];
  assign w_abs0 = w_s0 ? WIDTH'(-num0) : num0;
  assign w_abs1 = w_s1 ? WIDTH'(-num1) : num1;

  lut_digit_mult #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_lut (
    .i_mcand    (r_mcand),
    .i_digit    (r_mplier[DIGIT-1:0]),
    .o_multiple (w_lut)
  );

  assign w_term     = {{(2*WIDTH-LW){1'b0}}, w_lut} << (DIGIT * r_cnt);
  assign w_acc_nxt  = r_acc + w_term;
  assign w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = resetn;
        if (!flush && in_valid) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (flush)                  w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (flush || out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = in_valid && w_in_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_neg     <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op;
      r_neg    <= w_s0 ^ w_s1;
      r_mcand  <= w_abs0;
      r_mplier <= w_abs1;
      r_acc    <= '0;
    end else if ((r_state == S_CALC) && !flush) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier >> DIGIT;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_LAST) begin
        r_product <= w_prod_fix;
        r_result  <= (r_op == OP_MUL) ? w_prod_fix[WIDTH-1:0]
                                      : w_prod_fix[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign product   = r_product;
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_lut_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_multiplier_seq
//  Brief    : Directed-vector and corner-sequence bench for lut_multiplier_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lut_multiplier_seq;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] num0, num1, result;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  lut_multiplier_seq #(.WIDTH(32), .DIGIT(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .num0      (num0),
    .num1      (num1),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: sign/zero-extend to 64 bits and multiply mod 2^64.
  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = ((o == OP_MULH) || (o == OP_MULHSU)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit rand_rdy,
                       output logic [63:0] p, output logic [31:0] r, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    op = o; num0 = a; num1 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      lat++;
    end
    out_ready = 1'b0;
    p = product; r = result;
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) chk("hold_stable", product, p);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic quiet_window(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] p, e;
    logic [31:0] r, er;
    logic [1:0]  o;
    logic [31:0] a, b;
    int lat;

    vecs[0]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000};
    vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFF};
    vecs[3]  = '{OP_MULHU,  32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE, 32'h00000001};
    vecs[4]  = '{OP_MUL,    32'h00000007, 32'h00000006, 64'h000000000000002A, 32'h0000002A};
    vecs[5]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'h00000001};
    vecs[6]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 32'h00000000};
    vecs[7]  = '{OP_MULH,   32'h00000000, 32'h80000000, 64'h0000000000000000, 32'h00000000};
    vecs[8]  = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 64'h8000000080000000, 32'h80000000};
    vecs[9]  = '{OP_MULH,   32'h12345678, 32'hFFFFFFFE, 64'hFFFFFFFFDB975310, 32'hFFFFFFFF};
    vecs[10] = '{OP_MULHU,  32'h00010000, 32'h00010000, 64'h0000000100000000, 32'h00000001};
    vecs[11] = '{OP_MULH,   32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 32'hC0000000};

    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = OP_MUL; num0 = '0; num1 = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_product",   product,        64'd0);
    chk("rst_result",    64'(result),    64'd0);
    resetn = 1'b1;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, p, r, lat);
      chk($sformatf("vec%0d_product", i), p, vecs[i].p);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].r));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
    end

    // Backpressure: result held, in_ready low, extra in_valid ignored.
    op = OP_MUL; num0 = 32'd7; num1 = 32'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("bp_latency", 64'(lat), 64'd16);
    op = OP_MUL; num0 = 32'd3; num1 = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result_held", 64'(result), 64'h2A);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);
    quiet_window("bp_no_spurious_op", 20);

    // Flush at cnt=5.
    op = OP_MULHU; num0 = 32'hDEADBEEF; num1 = 32'h12345678; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    quiet_window("flush_no_out_valid", 20);

    // Flush beats in_valid in IDLE.
    op = OP_MUL; num0 = 32'd9; num1 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    quiet_window("flush_idle_no_capture", 20);

    // Flush while waiting in DONE drops the result.
    op = OP_MUL; num0 = 32'd2; num1 = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Async reset at cnt=9.
    op = OP_MULHU; num0 = 32'hFFFFFFFF; num1 = 32'hFFFFFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    resetn = 1'b0;
    #1;
    chk("arst_product", product, 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    do_op(OP_MUL, 32'd3, 32'd5, 0, 1'b0, p, r, lat);
    chk("post_rst_result", 64'(r), 64'd15);
    chk("post_rst_latency", 64'(lat), 64'd16);

    // Random sweep with random out_ready during calculation and random hold.
    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = 32'($urandom_range(0, 3)) - 32'd1;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
      e  = ref_prod(o, a, b);
      er = (o == OP_MUL) ? e[31:0] : e[63:32];
      do_op(o, a, b, $urandom_range(0, 2), 1'b1, p, r, lat);
      chk($sformatf("rnd%0d_product op=%0d a=%h b=%h", i, o, a, b), p, e);
      chk($sformatf("rnd%0d_result", i), 64'(r), 64'(er));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
